// File: rtl/pipe_stage_buf_pkg.sv
// Shared LC-3b pipeline types: inter-stage buffer state and occupancy decode.
package lc3b_types;

  localparam int unsigned LC3B_WORD_W = 16;
  localparam int unsigned OCC_W       = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_stage_state_t;

  // Number of payloads held in a given buffer state.
  function automatic logic [OCC_W-1:0] state_occupancy(input pipe_stage_state_t st);
    logic [OCC_W-1:0] occ;
    case (st)
      FULL:    occ = OCC_W'(1);
      SKID:    occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready inter-stage pipeline buffer with stall counter.
// PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_buf
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_stage_state_t state_q;
  pipe_stage_state_t state_d;
  logic [WIDTH-1:0]  main_q;
  logic [WIDTH-1:0]  main_d;
  logic              out_valid_q;
  logic [OCC_W-1:0]  occ_q;
  logic              accept;
  logic              transfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0]  skid_q;
  logic [WIDTH-1:0]  skid_d;
  logic              in_ready_q;

  assign in_ready = in_ready_q;
`else
  // Single-entry mode: room exists whenever the held entry leaves this cycle.
  assign in_ready = out_ready | ~out_valid_q;
`endif

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid_q & out_ready;

  // Next-state and payload steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        if (transfer && accept) begin
          main_d = in_data;
        end else if (transfer) begin
          state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
        end else if (accept) begin
          state_d = SKID;
          skid_d  = in_data;
`endif
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      SKID: begin
        if (transfer) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= state_occupancy(state_d);
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q  <= (state_d != SKID);
`endif
    end
  end

  // Payload storage carries no reset; validity lives in state_q.
  always_ff @(posedge clk) begin
    main_q <= main_d;
`ifdef PIPE_STAGE_SKID_EN
    skid_q <= skid_d;
`endif
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (out_valid_q & ~out_ready),
    .count   (stall_cnt)
  );

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = 15;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int checks;
  int failures;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] got[$];
  int unsigned      mcnt;
  logic             acc;
  int               k;

  pipe_stage_buf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected in_ready from the buffer's capacity rules.
  function automatic logic exp_ready(input logic r);
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return r || (mq.size() == 0);
`endif
  endfunction

  // One cycle: drive at negedge, check before posedge, advance the model.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic f,
                      input logic r, output logic accepted);
    logic rdy;
    logic xfer;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    rdy  = exp_ready(r);
    xfer = (mq.size() != 0) && r;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    if (out_valid && out_ready) got.push_back(out_data);
    accepted = v && rdy;
    @(posedge clk);
    if ((mq.size() != 0) && !r && (mcnt < CNT_MAX)) mcnt++;
    if (f) begin
      mq.delete();
    end else begin
      if (xfer) void'(mq.pop_front());
      if (accepted) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    mcnt      = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    // Single payload passes with one-cycle latency.
    step(1'b1, 16'h1234, 1'b0, 1'b1, acc);
    chk("first_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    #1;
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_data", 32'(out_data), 32'h1234);
    chk("lat_occupancy", 32'(occupancy), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Back-pressure: two pushes under stall, then drain in order.
    step(1'b1, 16'hA001, 1'b0, 1'b0, acc);
    step(1'b1, 16'hA002, 1'b0, 1'b0, acc);
    step(1'b1, 16'hA003, 1'b0, 1'b0, acc);
    step(1'b1, 16'hA003, 1'b0, 1'b0, acc);
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_occupancy", 32'(occupancy), 32'd2);
    chk("skid_in_ready", 32'(in_ready), 32'd0);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Flush while full with a concurrent push.
    step(1'b1, 16'hB001, 1'b0, 1'b0, acc);
    step(1'b1, 16'hB002, 1'b0, 1'b0, acc);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, acc);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Stall counter saturation.
    step(1'b1, 16'hC0DE, 1'b0, 1'b0, acc);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    chk("stall_sat", 32'(stall_cnt), 32'hF);
    step(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    chk("stall_hold", 32'(stall_cnt), 32'hF);

    // Asynchronous reset while holding data.
    step(1'b1, 16'hC001, 1'b0, 1'b0, acc);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 16'hC002, 1'b0, 1'b0, acc);
    chk("post_rst_accept", 32'(acc), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // 100 sequential payloads with random handshakes.
    got.delete();
    k = 0;
    for (int c = 0; c < 2000 && (k < 100 || mq.size() != 0); c++) begin
      step((k < 100) && ($urandom_range(0, 3) != 0), 16'(32'h5000 + k), 1'b0,
           $urandom_range(0, 1) == 1, acc);
      if (acc) k++;
    end
    chk("stream_len", 32'(got.size()), 32'd100);
    for (int i = 0; i < got.size() && i < 100; i++) begin
      chk("stream_seq", 32'(got[i]), 32'(32'h5000 + i));
    end

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 16, payload width in bits (16 = lc3b_word).
REQ-002 Parameter CNT_W, default 16, stall-counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream stage presents payload.
REQ-006 in_ready  output  1  stage can accept payload this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 flush  input  1  synchronous kill of all held entries.
REQ-009 out_valid  output  1  stage presents payload downstream.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  payload to downstream stage.
REQ-012 occupancy  output  2  number of held entries (0..2).
REQ-013 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Accept = in_valid & in_ready; transfer = out_valid & out_ready; both evaluated each rising edge.
REQ-015 Latency: payload accepted at edge N is on out_data with out_valid=1 from edge N to its transfer edge.
REQ-016 Payload order is preserved; no payload duplicated or dropped except by flush.
REQ-017 States: EMPTY (main invalid), FULL (main valid), SKID (main and skid valid); out_data always driven from main register.
REQ-018 EMPTY: accept -> FULL, main <= in_data.
REQ-019 FULL: transfer & accept -> FULL, main <= in_data; transfer only -> EMPTY; accept only -> SKID, skid <= in_data; neither -> FULL.
REQ-020 SKID: transfer -> FULL, main <= skid; no transfer -> SKID, registers held; no accept possible (in_ready=0).
REQ-021 out_valid = 1 in FULL and SKID, 0 in EMPTY.
REQ-022 occupancy = 0/1/2 for EMPTY/FULL/SKID.
REQ-023 flush = 1: next state EMPTY regardless of accept/transfer; input presented that cycle is dropped; a downstream transfer in the same cycle still counts as completed.
REQ-024 stall_cnt increments by 1 each cycle out_valid & ~out_ready, saturates at all-ones, unaffected by flush.
REQ-025 Payload registers are not reset; only valid state and counter are.

Reset
REQ-026 reset_n low: state EMPTY, out_valid=0, occupancy=0, stall_cnt=0, immediately (asynchronous).
REQ-027 Reset asserted mid-operation discards all held payloads; in_ready follows REQ-029/REQ-030 for EMPTY after release.
REQ-028 First accept possible on the first rising edge with reset_n high.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: skid register and SKID state present; in_ready is a registered signal, 1 in EMPTY and FULL, 0 in SKID, with no combinational path from out_ready.
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: no skid register or SKID state; in_ready = out_ready | ~out_valid (combinational); occupancy never exceeds 1; FULL with accept and no transfer cannot occur.

Structure
REQ-031 State enum pipe_stage_state_t (EMPTY, FULL, SKID) resides in package lc3b_types.
REQ-032 Saturating stall counter is a separate sub-module sat_counter parametrised by CNT_W with inc and asynchronous reset_n.
REQ-033 Block replaces fixed-register inter-stage buffers between IF/ID/EX/MEM/WB; stall is driven by out_ready of the next stage.

Verification
REQ-034 Reset, then in_data=16'h1234 in_valid=1 out_ready=1 -> out_valid=1, out_data=16'h1234 next cycle, occupancy=1.
REQ-035 SKID_EN, hold out_ready=0, push 16'hA001 then 16'hA002 -> occupancy=2, in_ready=0, stall_cnt increments each cycle; release out_ready -> A001 then A002 out in order.
REQ-036 flush=1 with occupancy=2 and in_valid=1 -> next cycle out_valid=0, occupancy=0, pushed payload never appears on out_data.
REQ-037 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=4'hF, holds at 4'hF.
REQ-038 Streaming 100 sequential payloads with random out_ready (both configurations) -> output sequence identical to input, no gaps while data available.
REQ-039 Assert reset_n low while occupancy=2 -> out_valid=0, stall_cnt=0 before next clock edge.
